// File: rtl/task2_pkg.sv
// task2_pkg
//   Shared definitions for the task2 front-end slice.
//   - W_DEFAULT : default word width of the task2 data path
//   - state_t   : sequencer FSM states (S_IDLE, S_STREAM, S_GAP)
package task2_pkg;

    localparam int unsigned W_DEFAULT = 33;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/task2_sequencer_rr_arbiter.sv
// rr_arbiter
//   Combinational N-way round-robin pick: the first requester at or after
//   ptr (wrapping) wins.
//   Ports:
//     req    in   N    request vector
//     ptr    in   IW   highest-priority index
//     grant  out  N    one-hot grant (zero when no request)
//     index  out  IW   index of the granted requester
//     any    out  1    at least one request present
module rr_arbiter
    import task2_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] pick;
    logic         found;

    // Requests at or above ptr take precedence; if there are none the
    // search wraps to the lowest-indexed request.
    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hi_mask[i] = (i >= 32'(ptr));
        end
        pick  = (|(req & hi_mask)) ? (req & hi_mask) : req;
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && pick[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                index    = IW'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/task2_sequencer.sv
// task2_sequencer
//   Shares one task2 analyzer core between N word-stream requesters.
//   Round-robin arbitration per packet, registered data/start toward the
//   core, a minimum idle gap between packets, packet-length truncation and
//   stall timeout.
//   Ports:
//     clock      in   1      single clock, posedge
//     reset      in   1      synchronous, active-high
//     req_valid  in   N      requester i has a word
//     req_data   in   N*W    word of requester i at [i*W +: W]
//     req_last   in   N      word is the last of its packet
//     req_ready  out  N      one-hot or zero; accept when valid & ready
//     data       out  W      registered word to task2
//     start      out  1      registered; 1 = data carries a packet word
//     grant_id   out  IW     owner of current or last packet
//     busy       out  1      sequencer not idle
//     trunc      out  1      pulse: packet cut at MAX_LEN
//     tmo        out  1      pulse: packet aborted on stall timeout
module task2_sequencer
    import task2_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned W       = W_DEFAULT,
    parameter int unsigned GAP     = 2,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 8,
    localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [N*W-1:0]  req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic [W-1:0]    data,
    output logic            start,
    output logic [IW-1:0]   grant_id,
    output logic            busy,
    output logic            trunc,
    output logic            tmo
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = $clog2(GAP + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  owner_q, owner_d;
    logic [W-1:0]  data_q, data_d;
    logic          start_q, start_d;
    logic          trunc_q, trunc_d;
    logic          tmo_q, tmo_d;
    logic [LW-1:0] len_q, len_d, len_inc;
    logic [SW-1:0] stall_q, stall_d, stall_inc;
    logic [GW-1:0] gap_q, gap_d;

    logic [N-1:0]  arb_grant;
    logic [IW-1:0] arb_index;
    logic          arb_any;

    logic          acc_valid;
    logic          acc_last;
    logic [W-1:0]  acc_word;
    logic          end_pkt;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .index (arb_index),
        .any   (arb_any)
    );

    assign acc_valid = req_valid[grant_q];
    assign acc_last  = req_last[grant_q];
    assign acc_word  = req_data[32'(grant_q) * W +: W];

    assign len_inc   = (len_q == LW'(MAX_LEN))   ? len_q   : len_q + LW'(1);
    assign stall_inc = (stall_q == SW'(TIMEOUT)) ? stall_q : stall_q + SW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        start_d = 1'b0;
        trunc_d = 1'b0;
        tmo_d   = 1'b0;
        len_d   = len_q;
        stall_d = stall_q;
        gap_d   = gap_q;
        end_pkt = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_index;
                    owner_d = arb_grant;
                    len_d   = '0;
                    stall_d = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (acc_valid) begin
                    data_d  = acc_word;
                    start_d = 1'b1;
                    len_d   = len_inc;
                    stall_d = '0;
                    // last on the MAX_LEN word is a normal end, not a cut
                    if (acc_last) begin
                        end_pkt = 1'b1;
                    end else if (len_inc == LW'(MAX_LEN)) begin
                        end_pkt = 1'b1;
                        trunc_d = 1'b1;
                    end
                end else begin
                    stall_d = stall_inc;
                    if (stall_inc == SW'(TIMEOUT)) begin
                        end_pkt = 1'b1;
                        tmo_d   = 1'b1;
                    end
                end
                if (end_pkt) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
                end
            end
            S_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            trunc_q <= 1'b0;
            tmo_q   <= 1'b0;
            len_q   <= '0;
            stall_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            start_q <= start_d;
            trunc_q <= trunc_d;
            tmo_q   <= tmo_d;
            len_q   <= len_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
        end
    end

    assign req_ready = (state_q == S_STREAM) ? owner_q : '0;
    assign data      = data_q;
    assign start     = start_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign trunc     = trunc_q;
    assign tmo       = tmo_q;

endmodule

// File: tb/tb_task2_sequencer.sv
// tb_task2_sequencer
//   Randomized and directed stimulus for task2_sequencer with N=2, GAP=2,
//   MAX_LEN=16, TIMEOUT=8. A timeline-based reference model predicts every
//   output each cycle; directed scenarios add packet-level checks.
module tb_task2_sequencer;

    localparam int unsigned N       = 2;
    localparam int unsigned W       = 33;
    localparam int unsigned GAP     = 2;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TIMEOUT = 8;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   data;
    logic           start;
    logic [0:0]     grant_id;
    logic           busy;
    logic           trunc;
    logic           tmo;

    task2_sequencer #(
        .N       (N),
        .W       (W),
        .GAP     (GAP),
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .data      (data),
        .start     (start),
        .grant_id  (grant_id),
        .busy      (busy),
        .trunc     (trunc),
        .tmo       (tmo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // requester word queues: {last, word}
    logic [W:0] q0[$];
    logic [W:0] q1[$];
    int         vprob[N];
    logic       rst_drv;
    logic [N-1:0] drv_valid;

    // reference model: packet timeline kept as owner + earliest free cycle
    int         m_owner;
    int         m_ptr;
    int         m_len;
    int         m_stall;
    int         m_now;
    int         m_free_at;
    logic [W-1:0] e_data;
    logic       e_start;
    logic       e_trunc;
    logic       e_tmo;
    int         e_gid;

    // observation counters
    int   obs_start;
    int   obs_trunc;
    int   obs_tmo;
    logic prev_start;
    int   zero_run;
    int   gseq[$];
    int   zruns[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int q_size(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [W:0] q_head(input int id);
        return (id == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int id);
        if (id == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
    endtask

    task automatic q_push(input int id, input logic [W:0] v);
        if (id == 0) q0.push_back(v);
        else         q1.push_back(v);
    endtask

    task automatic add_pkt(input int id, input int len, input bit with_last);
        logic [63:0] r;
        for (int j = 0; j < len; j++) begin
            r = {$urandom, $urandom};
            q_push(id, {(with_last && j == len - 1), r[W-1:0]});
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_len     = 0;
        m_stall   = 0;
        m_now     = 0;
        m_free_at = 0;
        e_data    = '0;
        e_start   = 1'b0;
        e_trunc   = 1'b0;
        e_tmo     = 1'b0;
        e_gid     = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic end_packet();
        m_ptr     = (m_owner + 1) % N;
        m_free_at = m_now + 1 + GAP;
        m_owner   = -1;
    endtask

    // Advance the model across the coming clock edge using the driven inputs.
    task automatic model_edge();
        logic [W:0] h;
        if (rst_drv) begin
            model_reset();
            return;
        end
        e_start = 1'b0;
        e_trunc = 1'b0;
        e_tmo   = 1'b0;
        if (m_owner >= 0) begin
            if (drv_valid[m_owner]) begin
                h = q_head(m_owner);
                q_pop(m_owner);
                e_data  = h[W-1:0];
                e_start = 1'b1;
                m_len++;
                m_stall = 0;
                if (h[W]) begin
                    end_packet();
                end else if (m_len == MAX_LEN) begin
                    end_packet();
                    e_trunc = 1'b1;
                end
            end else begin
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    end_packet();
                    e_tmo = 1'b1;
                end
            end
        end else if (m_now >= m_free_at && drv_valid != '0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && drv_valid[c]) m_owner = c;
            end
            e_gid   = m_owner;
            m_len   = 0;
            m_stall = 0;
        end
        m_now++;
    endtask

    task automatic drive();
        logic [W:0]  h;
        logic [63:0] r;
        for (int i = 0; i < N; i++) begin
            drv_valid[i] = (q_size(i) > 0) && (int'($urandom_range(99)) < vprob[i]);
            r = {$urandom, $urandom};
            h = drv_valid[i] ? q_head(i) : {1'b0, r[W-1:0]};
            req_data[i*W +: W] = h[W-1:0];
            req_last[i]        = h[W];
        end
        req_valid = drv_valid;
        reset     = rst_drv;
    endtask

    task automatic clear_obs();
        obs_start = 0;
        obs_trunc = 0;
        obs_tmo   = 0;
        zero_run  = 100;
        gseq.delete();
        zruns.delete();
    endtask

    // One clock: compare outputs of the previous edge, then drive and model the next.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        @(negedge clock);
        exp_ready = '0;
        if (m_owner >= 0) exp_ready[m_owner] = 1'b1;
        check_eq("start",     64'(start),     64'(e_start));
        check_eq("data",      64'(data),      64'(e_data));
        check_eq("grant_id",  64'(grant_id),  64'(e_gid));
        check_eq("busy",      64'(busy),      64'(m_owner >= 0 || m_now < m_free_at));
        check_eq("trunc",     64'(trunc),     64'(e_trunc));
        check_eq("tmo",       64'(tmo),       64'(e_tmo));
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        if (start) begin
            obs_start++;
            if (!prev_start) begin
                gseq.push_back(int'(grant_id));
                zruns.push_back(zero_run);
            end
            zero_run = 0;
        end else begin
            zero_run++;
        end
        obs_trunc += int'(trunc);
        obs_tmo   += int'(tmo);
        prev_start = start;
        drive();
        model_edge();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_obs();
        prev_start = 1'b0;
        vprob      = '{100, 100};
        rst_drv    = 1'b1;
        drv_valid  = '0;
        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        run(3);
        rst_drv = 1'b0;

        // contention from reset: alternating grants, gap between packets
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, 2, 1'b1);
            add_pkt(1, 2, 1'b1);
        end
        clear_obs();
        run(60);
        check_eq("t2_npkt", 64'(gseq.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < gseq.size()) check_eq("t2_grant", 64'(gseq[k]), 64'(k % 2));
        end
        for (int k = 1; k < 6; k++) begin
            if (k < zruns.size()) check_eq("t2_gap_ok", 64'(zruns[k] >= GAP + 1), 64'd1);
        end

        // single packet 3,4,5,9
        q_push(0, {1'b0, 33'd3});
        q_push(0, {1'b0, 33'd4});
        q_push(0, {1'b0, 33'd5});
        q_push(0, {1'b1, 33'd9});
        clear_obs();
        run(20);
        check_eq("t1_words", 64'(obs_start), 64'd4);
        check_eq("t1_trunc", 64'(obs_trunc), 64'd0);
        check_eq("t1_tmo",   64'(obs_tmo),   64'd0);
        check_eq("t1_npkt",  64'(gseq.size()), 64'd1);
        if (gseq.size() > 0) check_eq("t1_grant", 64'(gseq[0]), 64'd0);

        // truncation: 20 words, no last; tail times out
        add_pkt(1, 20, 1'b0);
        clear_obs();
        run(70);
        check_eq("t3_words", 64'(obs_start), 64'd20);
        check_eq("t3_trunc", 64'(obs_trunc), 64'd1);
        check_eq("t3_tmo",   64'(obs_tmo),   64'd1);

        // timeout: 2 words then silence; pointer moves past requester 0
        add_pkt(0, 2, 1'b0);
        clear_obs();
        for (int b = 0; b < 40 && obs_tmo == 0; b++) cycle();
        check_eq("t4_tmo_seen", 64'(obs_tmo),   64'd1);
        check_eq("t4_words",    64'(obs_start), 64'd2);
        add_pkt(0, 3, 1'b1);
        add_pkt(1, 3, 1'b1);
        run(6);
        check_eq("t4_next_grant", 64'(grant_id), 64'd1);
        run(30);

        // exact bound: last on word MAX_LEN
        add_pkt(0, MAX_LEN, 1'b1);
        clear_obs();
        run(40);
        check_eq("t6_words", 64'(obs_start), 64'(MAX_LEN));
        check_eq("t6_trunc", 64'(obs_trunc), 64'd0);

        // reset during word 2 of a 5-word packet
        add_pkt(0, 5, 1'b1);
        for (int b = 0; b < 20 && m_len < 1; b++) cycle();
        rst_drv = 1'b1;
        cycle();
        rst_drv = 1'b0;
        @(posedge clock);
        #1;
        check_eq("t5_start", 64'(start),     64'd0);
        check_eq("t5_data",  64'(data),      64'd0);
        check_eq("t5_busy",  64'(busy),      64'd0);
        check_eq("t5_ready", 64'(req_ready), 64'd0);
        add_pkt(0, 2, 1'b1);
        add_pkt(1, 2, 1'b1);
        clear_obs();
        run(20);
        check_eq("t5_npkt", 64'(gseq.size() >= 1), 64'd1);
        if (gseq.size() > 0) check_eq("t5_first_grant", 64'(gseq[0]), 64'd0);

        // randomized traffic with varying stall density
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                for (int i = 0; i < N; i++) begin
                    case ($urandom_range(3))
                        0:       vprob[i] = 100;
                        1:       vprob[i] = 85;
                        2:       vprob[i] = 50;
                        default: vprob[i] = 20;
                    endcase
                end
            end
            for (int i = 0; i < N; i++) begin
                if (q_size(i) < 3 && $urandom_range(9) == 0)
                    add_pkt(i, int'($urandom_range(22, 1)), $urandom_range(9) != 0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
